// File: rtl/rcvr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_pkg
// Description : Definitions shared by the rcvr serial receiver and the
//               rcvr_arb drain controller: the frame header byte and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rcvr_pkg;

  // Frame header byte recognised by the receivers.
  localparam logic [7:0] RCVR_MATCH = 8'hA5;

  // IDLE : the arbiter may grant a channel this cycle.
  // GRANT: rx_reading is driven this cycle.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rcvr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_arb_if
// Description : Valid/ready byte stream from the drain controller to the
//               downstream consumer.
//               m_valid : byte available          (master -> slave)
//               m_ready : consumer takes the byte (slave  -> master)
//               m_data  : byte                    (master -> slave)
//               m_chan  : source channel, CW bits (master -> slave)
//               m_ovr   : overrun tag             (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface rcvr_arb_if #(
  parameter int CW = 2
);
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic [CW-1:0] m_chan;
  logic          m_ovr;

  modport master (output m_valid, m_data, m_chan, m_ovr, input m_ready);
  modport slave  (input m_valid, m_data, m_chan, m_ovr, output m_ready);
endinterface
`default_nettype wire

// File: rtl/rcvr_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_arb_fifo
// Description : Synchronous FIFO holding tagged bytes. Head entry is read
//               combinationally from storage; full/empty are registered.
//               Ports: clock, reset (async, active-high), push/wdata,
//               pop (ignored while empty), rdata (head), full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rcvr_arb_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nxt;
  logic          do_pop, do_push;

  // A push into a full FIFO is accepted only when a pop frees the slot
  // in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      // Cleared so the head outputs read zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end
endmodule
`default_nettype wire

// File: rtl/rcvr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_arb
// Description : Round-robin drain controller for a bank of rcvr receivers.
//               Grants one ready+enabled channel at a time, pulses its
//               rx_reading for one cycle, and queues {byte, channel, overrun}
//               into an output FIFO feeding a valid/ready stream.
//               Ports: clock, reset (async, active-high), rx_ready,
//               rx_overrun, rx_data (8 bits per channel), rx_reading
//               (one-hot pulse), chan_en (enable mask), m (stream master),
//               fifo_full, ovr_cnt (8 bits per channel).
//               Optional: define RCVR_ARB_OVR_CNT_EN for per-channel
//               saturating overrun counters; otherwise ovr_cnt is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rcvr_arb
  import rcvr_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   rx_ready,
  input  logic [NCH-1:0]   rx_overrun,
  input  logic [8*NCH-1:0] rx_data,
  output logic [NCH-1:0]   rx_reading,
  input  logic [NCH-1:0]   chan_en,
  rcvr_arb_if.master       m,
  output logic             fifo_full,
  output logic [8*NCH-1:0] ovr_cnt
);
  localparam int CW = $clog2(NCH);
  localparam int FW = 8 + CW + 1;

  arb_state_t     state, state_nxt;
  logic [CW-1:0]  rr, rr_nxt, win;
  logic [NCH-1:0] cand, reading_nxt;
  logic [CW:0]    idx;
  logic           found, room, push, full, empty;
  logic [7:0]     rx_byte [NCH];
  logic [FW-1:0]  head;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign rx_byte[i] = rx_data[8*i +: 8];
  end

  assign cand = rx_ready & chan_en;
  // A pop in the same cycle frees a slot for the push.
  assign room = ~full | (m.m_ready & ~empty);

  // First candidate at or above rr, wrapping modulo NCH.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr} + (CW+1)'(k);
      if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
      if (!found && cand[idx[CW-1:0]]) begin
        found = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    reading_nxt = '0;
    rr_nxt      = rr;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (found && room) begin
          state_nxt   = GRANT;
          reading_nxt = NCH'(1) << win;
          rr_nxt      = (win == CW'(NCH-1)) ? '0 : win + 1'b1;
          push        = 1'b1;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= '0;
      rx_reading <= '0;
    end else begin
      state      <= state_nxt;
      rr         <= rr_nxt;
      rx_reading <= reading_nxt;
    end
  end

  rcvr_arb_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({rx_byte[win], win, rx_overrun[win]}),
    .pop   (m.m_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign m.m_valid                      = ~empty;
  assign {m.m_data, m.m_chan, m.m_ovr} = head;
  assign fifo_full                      = full;

`ifdef RCVR_ARB_OVR_CNT_EN
  for (genvar i = 0; i < NCH; i++) begin : g_ovr_cnt
    logic [7:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (push && win == CW'(i) && rx_overrun[i] && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
    assign ovr_cnt[8*i +: 8] = cnt;
  end
`else
  assign ovr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rcvr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcvr_arb
// Description : Self-checking bench for rcvr_arb. A transaction-level model
//               (rotating pointer as an integer, FIFO as a queue) predicts
//               grants and the output stream; receivers are modelled as
//               ready flags that drop after their grant completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcvr_arb;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(NCH);

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH-1:0]   rx_ready, rx_overrun, rx_reading, chan_en;
  logic [8*NCH-1:0] rx_data, ovr_cnt;
  logic             fifo_full;

  rcvr_arb_if #(.CW(CW)) m_if ();

  rcvr_arb #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .rx_data    (rx_data),
    .rx_reading (rx_reading),
    .chan_en    (chan_en),
    .m          (m_if),
    .fifo_full  (fifo_full),
    .ovr_cnt    (ovr_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         chan;
    logic       ovr;
  } ent_t;

  ent_t           mq[$];
  int             rr_m;
  logic [NCH-1:0] exp_reading;
  int             cnt_m [NCH];
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic model_reset();
    mq.delete();
    rr_m        = 0;
    exp_reading = '0;
    for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
  endtask

  function automatic logic [8*NCH-1:0] exp_ovr();
    logic [8*NCH-1:0] v;
    v = '0;
`ifdef RCVR_ARB_OVR_CNT_EN
    for (int i = 0; i < NCH; i++) v[8*i +: 8] = 8'(cnt_m[i]);
`endif
    return v;
  endfunction

  // Advance one clock: update the model from the inputs present this
  // cycle, step past the edge, then let receivers whose grant just ended
  // drop their ready flag.
  task automatic tick();
    logic [NCH-1:0] cand, ending;
    int             win;
    bit             pop, push;
    ent_t           e;
    if (reset) begin
      model_reset();
      @(posedge clock);
      #1;
      return;
    end
    ending = exp_reading;
    pop    = (mq.size() != 0) && m_if.m_ready;
    push   = 0;
    win    = -1;
    e      = '{data: 8'h00, chan: 0, ovr: 1'b0};
    exp_reading = '0;
    if (ending == '0) begin
      cand = rx_ready & chan_en;
      if (cand != '0 && (mq.size() < DEPTH || pop)) begin
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (rr_m + k) % NCH;
          if (win < 0 && cand[c]) win = c;
        end
        e.data = rx_data[8*win +: 8];
        e.chan = win;
        e.ovr  = rx_overrun[win];
        push   = 1;
        exp_reading[win] = 1'b1;
        rr_m = (win + 1) % NCH;
        if (e.ovr && cnt_m[win] < 255) cnt_m[win]++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    @(posedge clock);
    #1;
    rx_ready = rx_ready & ~ending;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    rx_ready   = '0;
    rx_overrun = '0;
    rx_data    = '0;
    chan_en    = '1;
    m_if.m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    rx_ready     = '1;
    rx_overrun   = '1;
    rx_data      = 32'hDEADBEEF;
    chan_en      = '1;
    m_if.m_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (rx_reading !== '0) begin n_fail++; $display("FAIL reset_reading got=%b exp=0", rx_reading); end
    n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", m_if.m_valid); end
    n_checks++; if (m_if.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", m_if.m_data); end
    n_checks++; if (m_if.m_chan !== '0) begin n_fail++; $display("FAIL reset_chan got=%0d exp=0", m_if.m_chan); end
    n_checks++; if (m_if.m_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", m_if.m_ovr); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    n_checks++; if (ovr_cnt !== '0) begin n_fail++; $display("FAIL reset_ovr_cnt got=%h exp=0", ovr_cnt); end
    apply_reset();
  endtask

  task automatic test_single_byte();
    apply_reset();
    m_if.m_ready = 1'b1;
    rx_data[8*2 +: 8] = 8'h3C;
    rx_ready = 4'b0100;
    tick();
    n_checks++; if (rx_reading !== 4'b0100) begin n_fail++; $display("FAIL single_reading got=%b exp=0100", rx_reading); end
    n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", m_if.m_valid); end
    n_checks++; if (m_if.m_data !== 8'h3C) begin n_fail++; $display("FAIL single_data got=%h exp=3c", m_if.m_data); end
    n_checks++; if (m_if.m_chan !== CW'(2)) begin n_fail++; $display("FAIL single_chan got=%0d exp=2", m_if.m_chan); end
    n_checks++; if (m_if.m_ovr !== 1'b0) begin n_fail++; $display("FAIL single_ovr got=%b exp=0", m_if.m_ovr); end
    tick();
    n_checks++; if (rx_reading !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_len got=%b exp=0000", rx_reading); end
    n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", m_if.m_valid); end
  endtask

  task automatic test_fairness();
    apply_reset();
    m_if.m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) rx_data[8*i +: 8] = 8'h10 + 8'(i);
    rx_ready = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_checks++;
        if (rx_reading !== (NCH'(1) << (k/2))) begin
          n_fail++; $display("FAIL fair_grant k=%0d got=%b exp=%b", k, rx_reading, NCH'(1) << (k/2));
        end
        n_checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_chan !== CW'(k/2)) begin
          n_fail++; $display("FAIL fair_chan k=%0d got v=%b ch=%0d exp v=1 ch=%0d", k, m_if.m_valid, m_if.m_chan, k/2);
        end
      end else begin
        n_checks++;
        if (rx_reading !== '0) begin n_fail++; $display("FAIL fair_gap k=%0d got=%b exp=0", k, rx_reading); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    m_if.m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) rx_data[8*i +: 8] = 8'h40 + 8'(i);
    rx_ready = '1;
    for (int k = 0; k < 7; k++) begin
      tick();
      // Channel 0 receives a fifth byte once its first one is taken.
      if (k == 1) begin
        rx_data[7:0] = 8'h55;
        rx_ready[0]  = 1'b1;
      end
    end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL bp_full got=%b exp=1", fifo_full); end
    n_checks++; if (mq.size() != DEPTH) begin n_fail++; $display("FAIL bp_model_depth got=%0d exp=%0d", mq.size(), DEPTH); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (rx_reading !== '0 || fifo_full !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold k=%0d got rd=%b full=%b exp rd=0 full=1", k, rx_reading, fifo_full);
      end
    end
    m_if.m_ready = 1'b1;
    tick();
    m_if.m_ready = 1'b0;
    n_checks++; if (rx_reading !== 4'b0001) begin n_fail++; $display("FAIL bp_fifth_grant got=%b exp=0001", rx_reading); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL bp_refull got=%b exp=1", fifo_full); end
    n_checks++; if (m_if.m_data !== 8'h41) begin n_fail++; $display("FAIL bp_head got=%h exp=41", m_if.m_data); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp1, exp_sat;
`ifdef RCVR_ARB_OVR_CNT_EN
    exp1 = 8'd1; exp_sat = 8'd255;
`else
    exp1 = 8'd0; exp_sat = 8'd0;
`endif
    apply_reset();
    m_if.m_ready = 1'b1;
    rx_data[15:8] = 8'hA5;
    rx_overrun    = 4'b0010;
    rx_ready      = 4'b0010;
    tick();
    n_checks++; if (m_if.m_ovr !== 1'b1 || m_if.m_chan !== CW'(1)) begin n_fail++; $display("FAIL ovr_tag got ovr=%b ch=%0d exp ovr=1 ch=1", m_if.m_ovr, m_if.m_chan); end
    n_checks++; if (ovr_cnt[15:8] !== exp1) begin n_fail++; $display("FAIL ovr_cnt_first got=%0d exp=%0d", ovr_cnt[15:8], exp1); end
    tick();
    for (int n = 1; n < 300; n++) begin
      rx_ready[1] = 1'b1;
      tick();
      tick();
    end
    n_checks++; if (ovr_cnt[15:8] !== exp_sat) begin n_fail++; $display("FAIL ovr_cnt_sat got=%0d exp=%0d", ovr_cnt[15:8], exp_sat); end
    n_checks++; if (ovr_cnt !== exp_ovr()) begin n_fail++; $display("FAIL ovr_cnt_all got=%h exp=%h", ovr_cnt, exp_ovr()); end
    rx_overrun = '0;
  endtask

  task automatic test_mask();
    bit seen;
    apply_reset();
    m_if.m_ready = 1'b1;
    chan_en  = 4'b1110;
    rx_ready = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      tick();
      n_checks++;
      if (rx_reading[0] !== 1'b0) begin n_fail++; $display("FAIL mask_block k=%0d got=%b exp=0", k, rx_reading[0]); end
    end
    chan_en = '1;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rx_reading[0] === 1'b1) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mask_release got=0 exp=1 (no grant within 2 cycles)"); end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    m_if.m_ready = 1'b1;
    rx_ready = 4'b1000;
    tick();
    n_checks++; if (rx_reading !== 4'b1000) begin n_fail++; $display("FAIL midrst_grant got=%b exp=1000", rx_reading); end
    reset = 1'b1;
    #1;
    n_checks++; if (rx_reading !== '0) begin n_fail++; $display("FAIL midrst_reading got=%b exp=0", rx_reading); end
    n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", m_if.m_valid); end
    tick();
    rx_ready = 4'b1010;
    reset    = 1'b0;
    tick();
    n_checks++; if (rx_reading !== 4'b0010) begin n_fail++; $display("FAIL midrst_first got=%b exp=0010", rx_reading); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) chan_en = (cyc % 128 == 0) ? '1 : NCH'($urandom);
      m_if.m_ready = (cyc < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      tick();
      n_checks++; if (rx_reading !== exp_reading) begin n_fail++; $display("FAIL rnd_reading cyc=%0d got=%b exp=%b", cyc, rx_reading, exp_reading); end
      n_checks++; if (m_if.m_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, m_if.m_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++;
        if ({m_if.m_data, m_if.m_chan, m_if.m_ovr} !== {mq[0].data, CW'(mq[0].chan), mq[0].ovr}) begin
          n_fail++; $display("FAIL rnd_head cyc=%0d got d=%h c=%0d o=%b exp d=%h c=%0d o=%b", cyc,
                             m_if.m_data, m_if.m_chan, m_if.m_ovr, mq[0].data, mq[0].chan, mq[0].ovr);
        end
      end
      n_checks++; if (fifo_full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, fifo_full, mq.size() == DEPTH); end
      n_checks++; if (ovr_cnt !== exp_ovr()) begin n_fail++; $display("FAIL rnd_ovr_cnt cyc=%0d got=%h exp=%h", cyc, ovr_cnt, exp_ovr()); end
      // New bytes complete in idle receivers.
      for (int i = 0; i < NCH; i++) begin
        if (!rx_ready[i] && $urandom_range(0, 3) == 0) begin
          rx_ready[i]       = 1'b1;
          rx_data[8*i +: 8] = 8'($urandom);
          rx_overrun[i]     = ($urandom_range(0, 3) == 0);
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    rx_ready     = '0;
    rx_overrun   = '0;
    rx_data      = '0;
    chan_en      = '1;
    m_if.m_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_byte();
    test_fairness();
    test_backpressure();
    test_overrun();
    test_mask();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
